// File: rtl/vga_char_pkg.sv
// Shared definitions for the VGA character writer.
// Contents: default screen geometry, ASCII control codes, the writer
// state type, and small helpers for row wrapping and cell addressing.
package vga_char_pkg;

    localparam int unsigned DEF_COLS      = 80;
    localparam int unsigned DEF_ROWS      = 60;
    localparam int unsigned DEF_ROW_SHIFT = 7;

    localparam logic [7:0] CH_BS    = 8'h08;
    localparam logic [7:0] CH_LF    = 8'h0A;
    localparam logic [7:0] CH_FF    = 8'h0C;
    localparam logic [7:0] CH_CR    = 8'h0D;
    localparam logic [7:0] CH_SPACE = 8'h20;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        CLEAR
    } wr_state_t;

    // Next row with wrap to the top; there is no scrolling.
    function automatic logic [5:0] row_after(input logic [5:0] y, input logic [5:0] last);
        return (y == last) ? 6'd0 : y + 6'd1;
    endfunction

    // Character buffer cell address {row, col}.
    function automatic logic [12:0] cell_addr(input logic [5:0] row, input logic [6:0] col,
                                              input int unsigned shift);
        return (13'(row) << shift) | 13'(col);
    endfunction

endpackage

// File: rtl/vga_char_cursor.sv
// Cursor position register for the VGA character writer.
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   adv                      step right, wrapping to the next row after the last column
//   newline                  column 0 and next row
//   cret                     column 0
//   bspace                   step left, wrapping to the end of the previous row
//   home                     back to (0,0)
//   x, y                     current column / row
//   row_advanced             high in the cycle a command moves the cursor to the next row
module vga_char_cursor
    import vga_char_pkg::*;
#(
    parameter int unsigned COLS = DEF_COLS,
    parameter int unsigned ROWS = DEF_ROWS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
    input  logic       newline,
    input  logic       cret,
    input  logic       bspace,
    input  logic       home,
    output logic [6:0] x,
    output logic [5:0] y,
    output logic       row_advanced
);

    localparam logic [6:0] X_LAST = 7'(COLS - 1);
    localparam logic [5:0] Y_LAST = 6'(ROWS - 1);

    assign row_advanced = newline | (adv & (x == X_LAST));

    always_ff @(posedge clk) begin
        if (rst || home) begin
            x <= '0;
            y <= '0;
        end else if (newline) begin
            x <= '0;
            y <= row_after(y, Y_LAST);
        end else if (adv) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= row_after(y, Y_LAST);
            end else begin
                x <= x + 7'd1;
            end
        end else if (cret) begin
            x <= '0;
        end else if (bspace) begin
            if (x != '0) begin
                x <= x - 7'd1;
            end else if (y != '0) begin
                x <= X_LAST;
                y <= y - 6'd1;
            end
        end
    end

endmodule

// File: rtl/vga_char_writer.sv
// Avalon-MM master turning an ASCII byte stream into writes on the VGA
// char_buffer_slave port, with cursor tracking, control characters and
// screen clear (0x0C).
// Optional feature: define VGA_CHAR_WRITER_LINE_CLEAR_EN to blank each
// newly entered row with spaces on every row advance.
// Ports:
//   sys_clk_clk, sys_reset_reset   clock, synchronous active-high reset
//   in_data/in_valid/in_ready      byte input handshake
//   cursor_x, cursor_y             current cursor position
//   busy                           high while a bus write or clear is in progress
//   char_address .. char_byteenable  registered Avalon-MM master outputs
//   char_waitrequest               slave stall
module vga_char_writer
    import vga_char_pkg::*;
#(
    parameter int unsigned COLS      = DEF_COLS,
    parameter int unsigned ROWS      = DEF_ROWS,
    parameter int unsigned ROW_SHIFT = DEF_ROW_SHIFT
) (
    input  logic        sys_clk_clk,
    input  logic        sys_reset_reset,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [6:0]  cursor_x,
    output logic [5:0]  cursor_y,
    output logic        busy,
    output logic [12:0] char_address,
    output logic        char_chipselect,
    output logic        char_write,
    output logic        char_read,
    output logic [7:0]  char_writedata,
    output logic        char_byteenable,
    input  logic        char_waitrequest
);

`ifdef VGA_CHAR_WRITER_LINE_CLEAR_EN
    localparam logic LINE_CLEAR = 1'b1;
`else
    localparam logic LINE_CLEAR = 1'b0;
`endif

    localparam logic [6:0] X_LAST = 7'(COLS - 1);
    localparam logic [5:0] Y_LAST = 6'(ROWS - 1);

    wr_state_t  state;
    logic [6:0] clr_col;
    logic [5:0] clr_row;
    logic       clr_full;

    logic       accept;
    logic       printable;
    logic       xfer_done;
    logic       clr_last;
    logic       cmd_adv;
    logic       cmd_newline;
    logic       cmd_cret;
    logic       cmd_bspace;
    logic       cmd_home;
    logic       row_advanced;
    logic [5:0] next_row;

    // Gated with reset so the block never advertises readiness while held in reset.
    assign in_ready        = (state == IDLE) && !sys_reset_reset;
    assign busy            = (state != IDLE);
    assign char_read       = 1'b0;
    assign char_byteenable = 1'b1;

    assign accept      = in_valid && in_ready;
    assign printable   = (in_data >= 8'h20) && (in_data <= 8'h7E);
    assign xfer_done   = !char_waitrequest;
    assign clr_last    = (clr_col == X_LAST) && (!clr_full || (clr_row == Y_LAST));
    assign cmd_newline = accept && (in_data == CH_LF);
    assign cmd_cret    = accept && (in_data == CH_CR);
    assign cmd_bspace  = accept && (in_data == CH_BS);
    assign cmd_adv     = (state == WRITE) && xfer_done;
    assign cmd_home    = (state == CLEAR) && xfer_done && clr_full && clr_last;
    assign next_row    = row_after(cursor_y, Y_LAST);

    vga_char_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk          (sys_clk_clk),
        .rst          (sys_reset_reset),
        .adv          (cmd_adv),
        .newline      (cmd_newline),
        .cret         (cmd_cret),
        .bspace       (cmd_bspace),
        .home         (cmd_home),
        .x            (cursor_x),
        .y            (cursor_y),
        .row_advanced (row_advanced)
    );

    always_ff @(posedge sys_clk_clk) begin
        if (sys_reset_reset) begin
            state           <= IDLE;
            char_address    <= '0;
            char_writedata  <= '0;
            char_write      <= 1'b0;
            char_chipselect <= 1'b0;
            clr_col         <= '0;
            clr_row         <= '0;
            clr_full        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (printable) begin
                            char_address    <= cell_addr(cursor_y, cursor_x, ROW_SHIFT);
                            char_writedata  <= in_data;
                            char_write      <= 1'b1;
                            char_chipselect <= 1'b1;
                            state           <= WRITE;
                        end else if (in_data == CH_FF) begin
                            clr_full        <= 1'b1;
                            clr_row         <= '0;
                            clr_col         <= '0;
                            char_address    <= '0;
                            char_writedata  <= CH_SPACE;
                            char_write      <= 1'b1;
                            char_chipselect <= 1'b1;
                            state           <= CLEAR;
                        end else if (LINE_CLEAR && cmd_newline) begin
                            // The first cell of the new row goes out with the accept edge.
                            clr_full        <= 1'b0;
                            clr_row         <= next_row;
                            clr_col         <= '0;
                            char_address    <= cell_addr(next_row, 7'd0, ROW_SHIFT);
                            char_writedata  <= CH_SPACE;
                            char_write      <= 1'b1;
                            char_chipselect <= 1'b1;
                            state           <= CLEAR;
                        end
                    end
                end

                WRITE: begin
                    if (xfer_done) begin
                        if (LINE_CLEAR && row_advanced) begin
                            clr_full       <= 1'b0;
                            clr_row        <= next_row;
                            clr_col        <= '0;
                            char_address   <= cell_addr(next_row, 7'd0, ROW_SHIFT);
                            char_writedata <= CH_SPACE;
                            state          <= CLEAR;
                        end else begin
                            char_write      <= 1'b0;
                            char_chipselect <= 1'b0;
                            state           <= IDLE;
                        end
                    end
                end

                CLEAR: begin
                    if (xfer_done) begin
                        if (clr_last) begin
                            char_write      <= 1'b0;
                            char_chipselect <= 1'b0;
                            state           <= IDLE;
                        end else if (clr_col == X_LAST) begin
                            clr_col      <= '0;
                            clr_row      <= clr_row + 6'd1;
                            char_address <= cell_addr(clr_row + 6'd1, 7'd0, ROW_SHIFT);
                        end else begin
                            clr_col      <= clr_col + 7'd1;
                            char_address <= cell_addr(clr_row, clr_col + 7'd1, ROW_SHIFT);
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_char_writer.sv
module tb_vga_char_writer;

`ifdef VGA_CHAR_WRITER_LINE_CLEAR_EN
    localparam bit LINE_CLEAR = 1'b1;
`else
    localparam bit LINE_CLEAR = 1'b0;
`endif

    localparam int COLS  = 80;
    localparam int ROWS  = 60;
    localparam int LIMIT = 20000;

    logic        sys_clk_clk      = 1'b0;
    logic        sys_reset_reset  = 1'b1;
    logic [7:0]  in_data          = 8'h00;
    logic        in_valid         = 1'b0;
    logic        in_ready;
    logic [6:0]  cursor_x;
    logic [5:0]  cursor_y;
    logic        busy;
    logic [12:0] char_address;
    logic        char_chipselect;
    logic        char_write;
    logic        char_read;
    logic [7:0]  char_writedata;
    logic        char_byteenable;
    logic        char_waitrequest = 1'b0;

    vga_char_writer #(
        .COLS      (COLS),
        .ROWS      (ROWS),
        .ROW_SHIFT (7)
    ) dut (
        .sys_clk_clk      (sys_clk_clk),
        .sys_reset_reset  (sys_reset_reset),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .cursor_x         (cursor_x),
        .cursor_y         (cursor_y),
        .busy             (busy),
        .char_address     (char_address),
        .char_chipselect  (char_chipselect),
        .char_write       (char_write),
        .char_read        (char_read),
        .char_writedata   (char_writedata),
        .char_byteenable  (char_byteenable),
        .char_waitrequest (char_waitrequest)
    );

    always #5 sys_clk_clk = ~sys_clk_clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Reference model: cursor as plain integers, expected writes as {addr, data}.
    int          mx = 0;
    int          my = 0;
    logic [20:0] exp_q[$];
    logic [20:0] obs_q[$];
    int          obs_cyc[$];
    int          cyc = 0;

    function automatic void push_exp(input int r, input int c, input logic [7:0] d);
        exp_q.push_back({13'(r * 128 + c), d});
    endfunction

    function automatic void model_row_adv();
        my = (my + 1) % ROWS;
        if (LINE_CLEAR)
            for (int c = 0; c < COLS; c++) push_exp(my, c, 8'h20);
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (b >= 8'h20 && b <= 8'h7E) begin
            push_exp(my, mx, b);
            mx++;
            if (mx == COLS) begin
                mx = 0;
                model_row_adv();
            end
        end else begin
            case (b)
                8'h0A: begin mx = 0; model_row_adv(); end
                8'h0D: mx = 0;
                8'h08: begin
                    if (mx > 0) mx--;
                    else if (my > 0) begin mx = COLS - 1; my--; end
                end
                8'h0C: begin
                    for (int r = 0; r < ROWS; r++)
                        for (int c = 0; c < COLS; c++) push_exp(r, c, 8'h20);
                    mx = 0;
                    my = 0;
                end
                default: ;
            endcase
        end
    endfunction

    // Bus monitor: records completed writes and checks outputs hold during stalls.
    logic        stall_prev = 1'b0;
    logic [12:0] addr_prev  = '0;
    logic [7:0]  data_prev  = '0;

    always @(negedge sys_clk_clk) begin
        cyc <= cyc + 1;
        if (!sys_reset_reset && stall_prev) begin
            chk("stall_addr", 32'(char_address), 32'(addr_prev));
            chk("stall_data", 32'(char_writedata), 32'(data_prev));
            chk("stall_write", 32'(char_write), 32'd1);
        end
        if (!sys_reset_reset && char_write && char_chipselect && !char_waitrequest) begin
            obs_q.push_back({char_address, char_writedata});
            obs_cyc.push_back(cyc);
        end
        stall_prev <= !sys_reset_reset && char_write && char_waitrequest;
        addr_prev  <= char_address;
        data_prev  <= char_writedata;
    end

    bit rand_wait = 1'b0;
    initial forever begin
        @(posedge sys_clk_clk);
        #1;
        if (rand_wait) char_waitrequest = ($urandom_range(0, 2) == 0);
    end

    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge sys_clk_clk);
        while (!in_ready && n < LIMIT) begin
            @(negedge sys_clk_clk);
            n++;
        end
        if (n >= LIMIT) chk("send_ready_timeout", 32'(in_ready), 32'd1);
        in_data  = b;
        in_valid = 1'b1;
        model_byte(b);
        @(posedge sys_clk_clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge sys_clk_clk);
        while (busy && n < LIMIT) begin
            @(negedge sys_clk_clk);
            n++;
        end
        if (busy) chk("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic stop_rand_wait();
        rand_wait = 1'b0;
        @(posedge sys_clk_clk);
        #1;
        char_waitrequest = 1'b0;
    endtask

    task automatic flush();
        obs_q.delete();
        obs_cyc.delete();
        exp_q.delete();
    endtask

    task automatic check_writes(input string tag);
        bit bad = 1'b0;
        int n;
        chk($sformatf("%s_count", tag), 32'(obs_q.size()), 32'(exp_q.size()));
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n && !bad; i++) begin
            chk($sformatf("%s_write%0d", tag, i), 32'(obs_q[i]), 32'(exp_q[i]));
            if (obs_q[i] !== exp_q[i]) bad = 1'b1;
        end
        flush();
    endtask

    task automatic chk_cursor(input string tag);
        chk($sformatf("%s_x", tag), 32'(cursor_x), 32'(mx));
        chk($sformatf("%s_y", tag), 32'(cursor_y), 32'(my));
    endtask

    function automatic logic [7:0] rand_byte();
        logic [7:0] junk [6] = '{8'h00, 8'h01, 8'h1B, 8'h7F, 8'h80, 8'hFF};
        int r = $urandom_range(0, 99);
        if (r < 70) return 8'($urandom_range(32, 126));
        if (r < 78) return 8'h0A;
        if (r < 84) return 8'h0D;
        if (r < 94) return 8'h08;
        return junk[$urandom_range(0, 5)];
    endfunction

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ea;
        int bc;
        int n;

        // Reset state
        repeat (3) @(negedge sys_clk_clk);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_write", 32'(char_write), 32'd0);
        chk("rst_cs", 32'(char_chipselect), 32'd0);
        chk("rst_addr", 32'(char_address), 32'd0);
        chk("rst_data", 32'(char_writedata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_read", 32'(char_read), 32'd0);
        chk("rst_byteenable", 32'(char_byteenable), 32'd1);
        chk_cursor("rst_cursor");
        @(posedge sys_clk_clk);
        #1;
        sys_reset_reset = 1'b0;
        @(negedge sys_clk_clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        flush();

        // 'H' 'i' back to back, no wait states
        send(8'h48);
        @(negedge sys_clk_clk);
        chk("h_write", 32'(char_write), 32'd1);
        chk("h_addr", 32'(char_address), 32'h0000);
        chk("h_data", 32'(char_writedata), 32'h48);
        chk("h_in_ready", 32'(in_ready), 32'd0);
        send(8'h69);
        wait_idle();
        if (obs_cyc.size() == 2) chk("hi_spacing", 32'(obs_cyc[1] - obs_cyc[0]), 32'd2);
        chk_cursor("hi_cursor");
        check_writes("hi");

        // Three waitrequest cycles on one write
        @(posedge sys_clk_clk);
        #1;
        char_waitrequest = 1'b1;
        ea = my * 128 + mx;
        send(8'h51);
        for (int k = 0; k < 4; k++) begin
            @(negedge sys_clk_clk);
            chk($sformatf("stall%0d_write", k), 32'(char_write), 32'd1);
            chk($sformatf("stall%0d_addr", k), 32'(char_address), 32'(ea));
            chk($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
            if (k == 2) begin
                @(posedge sys_clk_clk);
                #1;
                char_waitrequest = 1'b0;
            end
        end
        @(negedge sys_clk_clk);
        chk("stall_done_write", 32'(char_write), 32'd0);
        chk("stall_done_in_ready", 32'(in_ready), 32'd1);
        chk_cursor("stall_cursor");
        check_writes("stall");

        // Walk to (79,59) with random wait states, then wrap
        for (int i = 0; i < ROWS - 1; i++) send(8'h0A);
        rand_wait = 1'b1;
        for (int i = 0; i < COLS - 1; i++) send(8'($urandom_range(32, 126)));
        wait_idle();
        stop_rand_wait();
        chk_cursor("walk_cursor");
        check_writes("walk");
        send(8'h5A);
        @(negedge sys_clk_clk);
        chk("wrap_addr", 32'(char_address), 32'h1DCF);
        chk("wrap_data", 32'(char_writedata), 32'h5A);
        wait_idle();
        chk_cursor("wrap_cursor");
        check_writes("wrap");

        // Backspace / newline / junk handling
        send(8'h0A);
        send(8'h41);
        wait_idle();
        send(8'h08);
        @(negedge sys_clk_clk);
        chk_cursor("bs1_cursor");
        chk("bs1_in_ready", 32'(in_ready), 32'd1);
        send(8'h08);
        @(negedge sys_clk_clk);
        chk_cursor("bs2_cursor");
        chk("bs2_x_lit", 32'(cursor_x), 32'd79);
        check_writes("bs");
        send(8'h0D);
        send(8'h08);
        @(negedge sys_clk_clk);
        chk_cursor("bs_origin_cursor");
        send(8'h01);
        send(8'h7F);
        send(8'h0A);
        @(negedge sys_clk_clk);
        chk_cursor("lf_cursor");
        wait_idle();
        check_writes("ctrl");

        // Full-screen clear with no wait states
        send(8'h78);
        wait_idle();
        check_writes("pre_clear");
        send(8'h0C);
        bc = 0;
        n  = 0;
        @(negedge sys_clk_clk);
        while (busy && n < LIMIT) begin
            bc++;
            n++;
            @(negedge sys_clk_clk);
        end
        chk("clear_cycles", 32'(bc), 32'(ROWS * COLS));
        chk("clear_busy", 32'(busy), 32'd0);
        chk_cursor("clear_cursor");
        check_writes("clear");

        // Reset in the middle of a clear
        send(8'h0C);
        repeat (100) @(negedge sys_clk_clk);
        chk("midclear_write", 32'(char_write), 32'd1);
        sys_reset_reset = 1'b1;
        @(negedge sys_clk_clk);
        chk("midrst_write", 32'(char_write), 32'd0);
        chk("midrst_cs", 32'(char_chipselect), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        mx = 0;
        my = 0;
        chk_cursor("midrst_cursor");
        sys_reset_reset = 1'b0;
        @(negedge sys_clk_clk);
        chk("midrst_release_in_ready", 32'(in_ready), 32'd1);
        flush();

        // Random byte stream with random wait states
        rand_wait = 1'b1;
        for (int i = 0; i < 300; i++) send(rand_byte());
        wait_idle();
        stop_rand_wait();
        chk_cursor("rand_cursor");
        check_writes("rand");

        // LF at row 3: line clear only when the option is built in
        @(negedge sys_clk_clk);
        sys_reset_reset = 1'b1;
        @(negedge sys_clk_clk);
        sys_reset_reset = 1'b0;
        mx = 0;
        my = 0;
        for (int i = 0; i < 3; i++) send(8'h0A);
        wait_idle();
        flush();
        chk_cursor("row3_cursor");
        send(8'h0A);
        wait_idle();
        chk("lf_clear_count", 32'(obs_q.size()), LINE_CLEAR ? 32'd80 : 32'd0);
        chk("row4_y_lit", 32'(cursor_y), 32'd4);
        chk_cursor("row4_cursor");
        check_writes("lf_clear");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
